// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
// Optional perf counters are built when FETCH_PERF_EN is defined.
package mips_fetch_pkg;

  localparam logic [31:0] DEFAULT_HALT_PC = 32'd84;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALTED
  } fetchState_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetchEntry_t;

endpackage

// File: rtl/mips_fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry buffer of fetched words toward decode.
// Flush has priority over push and pop.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetchEntry_t      pushData,
  input  logic             pop,
  output fetchEntry_t      headData,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetchEntry_t      mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;

  assign headData = mem[rdPtr];
  assign empty    = (count == '0);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: owns the PC, reads imem and feeds decode.
// FETCH_PERF_EN adds perf_fetched / perf_stall counter ports.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] HALT_PC = DEFAULT_HALT_PC,
  parameter int          DEPTH   = 2
) (
  input  logic              LOOP,
  input  logic              reset_n,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [32:0] MEM_TOP = 33'd4 << ADDR_W;

  fetchState_t      state;
  fetchState_t      stateNext;
  logic [31:0]      pc;
  logic [31:0]      pcNext;
  logic             inflight;
  logic [31:0]      inflightPc;
  logic             issue;
  logic             pop;
  logic             stopPc;
  logic             room;
  logic [CNT_W:0]   occupancy;
  logic             fifoPush;
  logic             fifoPop;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  fetchEntry_t      fifoHead;
  fetchEntry_t      returnEntry;
  fetchEntry_t      headEntry;

  // The returning word is visible as head while the FIFO is empty.
  assign returnEntry = '{pc: inflightPc, instr: imem_rdata};
  assign headEntry   = fifoEmpty ? returnEntry : fifoHead;
  assign instr_valid = !fifoEmpty || inflight;
  assign instr       = instr_valid ? headEntry.instr : '0;
  assign instr_pc    = instr_valid ? headEntry.pc : '0;

  assign pop      = instr_valid && instr_ready;
  assign fifoPop  = pop && !fifoEmpty && !redirect_valid;
  assign fifoPush = inflight && !redirect_valid
                 && !(fifoEmpty && pop);

  assign occupancy = (CNT_W+1)'(fifoCount)
                   + (CNT_W+1)'(inflight)
                   - (CNT_W+1)'(pop);
  assign room      = occupancy < (CNT_W+1)'(DEPTH);
  assign stopPc    = (pc == HALT_PC)
                  || ({1'b0, pc} >= MEM_TOP);

  assign imem_addr  = pc[ADDR_W+1:2];
  assign imem_rd_en = issue && reset_n;
  assign halted     = (state == HALTED);

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    issue     = 1'b0;
    if (redirect_valid) begin
      stateNext = FETCH;
      pcNext    = redirect_pc & ~32'd3;
    end else begin
      unique case (state)
        FETCH: begin
          if (stopPc) begin
            stateNext = DRAIN;
          end else if (room) begin
            issue  = 1'b1;
            pcNext = pc + 32'd4;
          end
        end
        DRAIN: begin
          if (fifoEmpty && !inflight) begin
            stateNext = HALTED;
          end
        end
        HALTED: begin
          stateNext = HALTED;
        end
        default: begin
          stateNext = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge LOOP or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      pc         <= '0;
      inflight   <= 1'b0;
      inflightPc <= '0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      inflight <= issue;
      if (issue) begin
        inflightPc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (LOOP),
    .rst_n   (reset_n),
    .flush   (redirect_valid),
    .push    (fifoPush),
    .pushData(returnEntry),
    .pop     (fifoPop),
    .headData(fifoHead),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge LOOP or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && perf_fetched != '1) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (instr_valid && !instr_ready
          && perf_stall != '1) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: vector table, directed corners,
// and random ready/redirect traffic against a PC-stream model.
`timescale 1ns/1ps
module tb_mips_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] HALT  = 32'd84;
  localparam logic [31:0] TOP   = 32'd4096;

  logic        LOOP = 1'b0;
  logic        reset_n = 1'b0;
  logic        imemRdEn;
  logic [9:0]  imemAddr;
  logic [31:0] imemRdata = 32'h0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched;
  logic [31:0] perfStall;
`endif

  mips_fetch_unit dut (
    .LOOP          (LOOP),
    .reset_n       (reset_n),
    .imem_rd_en    (imemRdEn),
    .imem_addr     (imemAddr),
    .imem_rdata    (imemRdata),
    .instr_valid   (instrValid),
    .instr_ready   (instrReady),
    .instr         (instr),
    .instr_pc      (instrPc),
    .redirect_valid(redirectValid),
    .redirect_pc   (redirectPc),
`ifdef FETCH_PERF_EN
    .perf_fetched  (perfFetched),
    .perf_stall    (perfStall),
`endif
    .halted        (halted)
  );

  always #5 LOOP = ~LOOP;

  logic [31:0] mem [1024];
  int          readHits [1024];
  int          totalReads = 0;

  always @(posedge LOOP) begin
    if (imemRdEn) begin
      imemRdata <= mem[imemAddr];
      readHits[imemAddr] = readHits[imemAddr] + 1;
      totalReads = totalReads + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit rdy, input bit rv,
                      input logic [31:0] rp);
    @(negedge LOOP);
    reset_n       = 1'b1;
    instrReady    = rdy;
    redirectValid = rv;
    redirectPc    = rp;
    #1;
  endtask

  task automatic holdReset(input int n);
    reset_n       = 1'b0;
    instrReady    = 1'b0;
    redirectValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge LOOP);
      #1;
      check("rst rd_en", {31'b0, imemRdEn}, 0);
      check("rst valid", {31'b0, instrValid}, 0);
      check("rst halted", {31'b0, halted}, 0);
      check("rst instr", instr, 0);
      check("rst instr_pc", instrPc, 0);
`ifdef FETCH_PERF_EN
      check("rst perf_fetched", perfFetched, 0);
      check("rst perf_stall", perfStall, 0);
`endif
    end
  endtask

  typedef struct {
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          eRd;
    logic [9:0]  eAddr;
    bit          eValid;
    logic [31:0] ePc;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expPc;
    logic [31:0] tgt;
    int          base;
    int          baseReads;
    int          pops;
    int          stalls;
    bit          rdy;
    bit          rv;
    bit          prevRedir;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h20080001 + i;
    end

    // backpressure for 5 cycles, then redirect to 0x2E with PC 12 at head
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 10'd0,  1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 10'd1,  1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 10'd2,  1'b1, 32'h4};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 10'd3,  1'b1, 32'h8};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 10'd4,  1'b1, 32'h8};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 10'd4,  1'b1, 32'h8};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 10'd4,  1'b1, 32'h8};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 10'd4,  1'b1, 32'h8};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 10'd4,  1'b1, 32'h8};
    vecs[9]  = '{1'b1, 1'b1, 32'h2E, 1'b0, 10'd5,  1'b1, 32'hC};
    vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 10'd11, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 10'd12, 1'b1, 32'h2C};
    vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 10'd13, 1'b1, 32'h30};

    // reset, then full stream 0..80 with halt
    holdReset(3);
    step(1'b1, 1'b0, 32'h0);
    check("c0 rd_en", {31'b0, imemRdEn}, 1);
    check("c0 addr", {22'b0, imemAddr}, 0);
    check("c0 valid", {31'b0, instrValid}, 0);
    base = readHits[21];
    for (int k = 0; k <= 20; k++) begin
      step(1'b1, 1'b0, 32'h0);
      check("stream valid", {31'b0, instrValid}, 1);
      check("stream pc", instrPc, 32'(4 * k));
      check("stream instr", instr, mem[k]);
    end
    step(1'b1, 1'b0, 32'h0);
    check("post80 valid", {31'b0, instrValid}, 0);
    check("post80+1 halted", {31'b0, halted}, 0);
    step(1'b1, 1'b0, 32'h0);
    check("post80+2 halted", {31'b0, halted}, 1);
    check("no word21 read", 32'(readHits[21] - base), 0);

    // redirect out of HALTED
    step(1'b1, 1'b1, 32'h10);
    check("halted before redir", {31'b0, halted}, 1);
    step(1'b1, 1'b0, 32'h0);
    check("unhalt", {31'b0, halted}, 0);
    check("unhalt bubble", {31'b0, instrValid}, 0);
    for (int k = 4; k <= 20; k++) begin
      step(1'b1, 1'b0, 32'h0);
      check("rehalt stream pc", instrPc, 32'(4 * k));
      check("rehalt stream valid", {31'b0, instrValid}, 1);
    end
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("rehalt halted", {31'b0, halted}, 1);

    // vector table
    holdReset(3);
    baseReads = totalReads;
    pops = 0;
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      check("vec rd_en", {31'b0, imemRdEn}, {31'b0, vecs[i].eRd});
      check("vec addr", {22'b0, imemAddr}, {22'b0, vecs[i].eAddr});
      check("vec valid", {31'b0, instrValid},
            {31'b0, vecs[i].eValid});
      if (vecs[i].eValid) begin
        check("vec pc", instrPc, vecs[i].ePc);
        check("vec instr", instr, mem[vecs[i].ePc[11:2]]);
      end
      if (i < 9) begin
        check("vec buffered",
              {31'b0, (totalReads - baseReads - pops) <= DEPTH}, 1);
        if (instrValid && vecs[i].rdy) pops++;
      end
    end

    // top of imem: stop before 4096 without wrapping to word 0
    base = readHits[0];
    step(1'b1, 1'b1, TOP - 32'd8);
    step(1'b1, 1'b0, 32'h0);
    check("top bubble", {31'b0, instrValid}, 0);
    step(1'b1, 1'b0, 32'h0);
    check("top pc0", instrPc, TOP - 32'd8);
    step(1'b1, 1'b0, 32'h0);
    check("top pc1", instrPc, TOP - 32'd4);
    step(1'b1, 1'b0, 32'h0);
    check("top drained", {31'b0, instrValid}, 0);
    step(1'b1, 1'b0, 32'h0);
    check("top halted", {31'b0, halted}, 1);
    check("top no wrap", 32'(readHits[0] - base), 0);

    // random ready / redirect traffic
    expPc = TOP;
    baseReads = totalReads;
    pops = 0;
    prevRedir = 1'b0;
    for (int n = 0; n < 800; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0)
        tgt = TOP - 32'(4 * $urandom_range(1, 3))
            + 32'($urandom_range(0, 3));
      else
        tgt = 32'(4 * $urandom_range(0, 22))
            + 32'($urandom_range(0, 3));
      step(rdy, rv, tgt);
      if (prevRedir)
        check("rand redir bubble", {31'b0, instrValid}, 0);
      if (instrValid) begin
        check("rand no overrun",
              {31'b0, expPc != HALT && expPc < TOP}, 1);
        check("rand pc", instrPc, expPc);
        check("rand instr", instr, mem[expPc[11:2]]);
        if (rdy) begin
          expPc = expPc + 32'd4;
          pops++;
        end
      end
      check("rand buffered",
            {31'b0, (totalReads - baseReads - pops) <= DEPTH}, 1);
      if (halted)
        check("rand halt pos",
              {31'b0, expPc == HALT || expPc >= TOP}, 1);
      if (rv) begin
        expPc = tgt & ~32'd3;
        baseReads = totalReads;
        pops = 0;
      end
      prevRedir = rv;
    end

    step(1'b1, 1'b1, 32'h40);
    expPc = 32'h40;
    for (int n = 0; n < 200 && !halted; n++) begin
      step(1'b1, 1'b0, 32'h0);
      if (instrValid) begin
        check("drain pc", instrPc, expPc);
        expPc = expPc + 32'd4;
      end
    end
    check("drain halted", {31'b0, halted}, 1);
    check("drain end pc", expPc, HALT);

    // async reset with two words buffered
    holdReset(2);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("pre-reset valid", {31'b0, instrValid}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst valid", {31'b0, instrValid}, 0);
    check("async rst rd_en", {31'b0, imemRdEn}, 0);
    check("async rst instr_pc", instrPc, 0);
    holdReset(2);

    // 10 pops with 3 stall cycles
    pops = 0;
    stalls = 0;
    expPc = 32'h0;
    for (int n = 0; n < 40 && pops < 10; n++) begin
      rdy = !(n >= 3 && n < 6);
      step(rdy, 1'b0, 32'h0);
      if (instrValid) begin
        check("perf phase pc", instrPc, expPc);
        if (rdy) begin
          pops++;
          expPc = expPc + 32'd4;
        end else begin
          stalls++;
        end
      end
    end
    check("perf pops reached", 32'(pops), 10);
    check("perf stalls seen", 32'(stalls), 3);
    step(1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perfFetched, 32'd10);
    check("perf_stall", perfStall, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage for the single-cycle-derived MIPS core. Sits directly upstream of the decode/register-file path and owns the PC. Drives the instruction memory (word-indexed, 1-cycle synchronous read) and buffers fetched words in a small FIFO toward decode through a valid/ready handshake. Stops fetching at a configured end-of-program PC or at the top of instruction memory.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width (1024 words).
- `HALT_PC`, 32'd84: byte PC at which fetch stops.
- `DEPTH`, 2: FIFO depth; legal values are 2 or 4.
- `LOOP`, in, 1: clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `imem_rd_en`, out, 1: instruction-memory read strobe.
- `imem_addr`, out, ADDR_W: word address, equal to `pc[ADDR_W+1:2]`.
- `imem_rdata`, in, 32: read data, valid the cycle after `imem_rd_en`.
- `instr_valid`, out, 1: FIFO head is valid.
- `instr_ready`, in, 1: decode accepts the head.
- `instr`, out, 32: head instruction word.
- `instr_pc`, out, 32: byte PC of the head.
- `redirect_valid`, in, 1: a branch or jump was taken.
- `redirect_pc`, in, 32: target byte PC; bits [1:0] are ignored and forced to 0.
- `halted`, out, 1: fetch is stopped and all output is drained.

## Operation
- States: FETCH, DRAIN, HALTED. Reset state is FETCH.
- Reset values: `pc` = 0, FIFO empty, no read in flight, `instr_valid` = 0, `halted` = 0, `imem_rd_en` = 0 while `reset_n` is low, `instr` and `instr_pc` = 0.
- Issue rule: in FETCH, assert `imem_rd_en` when (count + inflight − pop) < DEPTH and no redirect is active. Here pop = `instr_valid` & `instr_ready`. On issue, `pc` += 4.
- Return: the in-flight word is pushed to the FIFO with its PC the cycle after issue.
- Pop: the FIFO head advances when `instr_valid` and `instr_ready` are both high.
- FETCH → DRAIN when the `pc` about to issue equals `HALT_PC` or equals 4·2^ADDR_W. No read is issued for that PC.
- DRAIN → HALTED when the FIFO is empty and nothing is in flight.
- `halted` is high only in HALTED.
- Redirect, in any state: same cycle, suppress the issue. Next edge:
  - discard the in-flight read and all FIFO entries;
  - set `pc` = target;
  - go to FETCH. This clears `halted`.
- A redirect wins over a simultaneous pop, push, or halt detection. If the target equals `HALT_PC`, the unit enters DRAIN on the following cycle.
- The address never wraps. Fetch stops before 4·2^ADDR_W.

## Timing
- First read: cycle 0 after `reset_n` rises (`imem_addr` = 0).
- First `instr_valid`: after the following edge, giving 1 cycle of fetch-to-valid latency.
- Steady state with `instr_ready` held high: one instruction per cycle, no bubbles.
- `instr_ready` low: issue stops once count + inflight reaches DEPTH. No word is lost or duplicated.
- Redirect asserted in cycle n: FIFO empty and `instr_valid` = 0 in cycle n+1. Target read in n+1, target valid in n+2.
- `reset_n` asserted mid-stream: all state clears immediately, asynchronously. The in-flight read is dropped.

## Configuration
- `FETCH_PERF_EN` defined: adds two output ports.
  - `perf_fetched` (32): increments on each pop.
  - `perf_stall` (32): increments each cycle with `instr_valid` & !`instr_ready`.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package `mips_fetch_pkg` holds:
  - the state enum (FETCH, DRAIN, HALTED);
  - `DEFAULT_HALT_PC` = 84;
  - `INSTR_W` = 32;
  - the FIFO entry struct {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`: synchronous FIFO of DEPTH entries with push/pop/flush and a count output. Flush has priority over push.

## Test plan
- Reset: hold `reset_n` low for 3 cycles. All outputs match the reset values, and `imem_rd_en` = 0 during reset. After release, `imem_addr` = 0 in cycle 0.
- Streaming: load words 0x20080001.. at addresses 0..20 and hold `instr_ready` = 1. The unit delivers `instr_pc` 0, 4, …, 80 on consecutive cycles. `halted` rises 2 cycles after the PC-80 pop, and no read of word 21 occurs.
- Backpressure: drop `instr_ready` for 5 cycles mid-stream. At most DEPTH words are buffered, and the sequence resumes without loss or duplicates.
- Redirect: assert `redirect_valid` with `redirect_pc` = 0x2E while PC 12 is at the head. Next cycle `instr_valid` = 0. The cycle after, `instr_pc` = 0x2C.
- Redirect from HALTED: with the unit halted, redirect to 0x10. `halted` drops and 0x10, 0x14, … stream again until 84.
- Reset mid-operation and, with `FETCH_PERF_EN` defined, counters: assert `reset_n` while 2 words are buffered. `instr_valid` drops immediately. After 10 pops with 3 stall cycles, `perf_fetched` = 10 and `perf_stall` = 3.
